// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// clocks-per-bit helper used by both TX and RX.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  function automatic int calc_bit_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..BIT_DIV-1, wraps by itself and flags the last
// clock of each bit; clr realigns it to a new bit boundary.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int BIT_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // baud count register with sync clear and natural wrap at the bit end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr || bit_end) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign bit_end = (cnt_r == LAST_CNT);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// 8N1 UART transmitter that drains a FIFO read port, one pop per frame,
// chaining frames back-to-back while data is available.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty,
  input  logic [7:0] rdata,
  output logic       pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BIT_DIV = calc_bit_div(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e state_r;
  uart_state_e state_nxt_s;
  logic [7:0]  shift_r;
  logic [7:0]  shift_nxt_s;
  logic [2:0]  bit_cnt_r;
  logic [2:0]  bit_cnt_nxt_s;
  logic        tx_r;
  logic        tx_nxt_s;
  logic        busy_r;
  logic        bit_end_s;
  logic        clr_s;
  logic        pop_s;

  // counter restarts on every state change so bits align to the frame start
  assign clr_s = (state_nxt_s != state_r);

  uart_baud_cnt #(
    .BIT_DIV (BIT_DIV)
  ) u_baud_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_s),
    .bit_end (bit_end_s)
  );

  // next-state, pop and shift-register decisions
  always_comb begin
    state_nxt_s   = state_r;
    shift_nxt_s   = shift_r;
    bit_cnt_nxt_s = bit_cnt_r;
    pop_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty) begin
          pop_s       = 1'b1;
          shift_nxt_s = rdata;
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_nxt_s   = DATA;
          bit_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_nxt_s   = {1'b0, shift_r[7:1]};
          bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt_s = STOP;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      STOP: begin
        // a waiting byte is taken on the stop's last clock: no idle gap
        if (bit_end_s && !empty) begin
          pop_s       = 1'b1;
          shift_nxt_s = rdata;
          state_nxt_s = START;
        end else if (bit_end_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // line level for the coming cycle, derived from the state being entered
  always_comb begin
    tx_nxt_s = 1'b1;
    case (state_nxt_s)
      START:   tx_nxt_s = 1'b0;
      DATA:    tx_nxt_s = shift_nxt_s[0];
      default: tx_nxt_s = 1'b1;
    endcase
  end

  // FSM state, shifter and registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      shift_r   <= shift_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      tx_r      <= tx_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
    end
  end

  assign pop     = pop_s & ~rst;
  assign tx      = tx_r;
  assign tx_busy = busy_r;
  assign tx_done = (state_r == STOP) & bit_end_s & ~rst;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain at BIT_DIV=10 with a small FIFO model
// and per-cycle logging of the line outputs.
module tb_uart_tx_fifo_drain;

  localparam int SEL_TX   = 0;
  localparam int SEL_POP  = 1;
  localparam int SEL_DONE = 2;
  localparam int SEL_BUSY = 3;

  logic       clk;
  logic       rst;
  logic       empty;
  logic [7:0] rdata;
  logic       pop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_checks;
  int n_fail;

  logic [7:0] q[$];
  logic [7:0] idle_data;
  logic [7:0] push_val;
  int         push_at;
  int         rst_at;
  logic       pop_prev;

  logic tx_log   [0:399];
  logic pop_log  [0:399];
  logic done_log [0:399];
  logic busy_log [0:399];

  uart_tx_fifo_drain #(
    .CLK_FREQ (1_000_000),
    .BAUD     (100_000)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .empty   (empty),
    .rdata   (rdata),
    .pop     (pop),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: update FIFO model after the edge, drive inputs, then log outputs.
  task automatic step(input int i);
    @(posedge clk);
    #1;
    if (pop_prev && q.size() != 0) void'(q.pop_front());
    if (i == push_at) q.push_back(push_val);
    rst   = (i == rst_at);
    empty = (q.size() == 0);
    rdata = (q.size() != 0) ? q[0] : idle_data;
    #1;
    tx_log[i]   = tx;
    pop_log[i]  = pop;
    done_log[i] = tx_done;
    busy_log[i] = tx_busy;
    pop_prev    = pop;
  endtask

  task automatic run(input int ncyc);
    pop_prev = 1'b0;
    for (int i = 0; i < ncyc; i++) step(i);
    push_at = -1;
    rst_at  = -1;
  endtask

  function automatic int count_val(input int sel, input int lo, input int hi, input logic v);
    int n;
    n = 0;
    for (int k = lo; k <= hi; k++) begin
      case (sel)
        SEL_TX:   if (tx_log[k] === v) n++;
        SEL_POP:  if (pop_log[k] === v) n++;
        SEL_DONE: if (done_log[k] === v) n++;
        SEL_BUSY: if (busy_log[k] === v) n++;
        default:  n = n;
      endcase
    end
    return n;
  endfunction

  // Mid-bit sample of the 8 data bits of a frame whose start bit begins at s.
  function automatic logic [7:0] decode(input int s);
    logic [7:0] d;
    for (int b = 0; b < 8; b++) d[b] = tx_log[s + 15 + 10 * b];
    return d;
  endfunction

  initial begin
    logic [9:0] fb;
    int         mism;
    n_checks  = 0;
    n_fail    = 0;
    push_at   = -1;
    rst_at    = -1;
    push_val  = 8'h00;
    idle_data = 8'h00;
    pop_prev  = 1'b0;
    rst       = 1'b1;
    empty     = 1'b1;
    rdata     = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_pop", pop, 1'b0);
    rst = 1'b0;

    // idle with an empty FIFO
    run(200);
    chk("idle_tx_high", count_val(SEL_TX, 0, 199, 1'b1), 200);
    chk("idle_no_pop", count_val(SEL_POP, 0, 199, 1'b1), 0);
    chk("idle_not_busy", count_val(SEL_BUSY, 0, 199, 1'b1), 0);

    // single byte 8'hA5
    q = {8'hA5};
    idle_data = 8'hFF;
    run(110);
    chk("a5_pop_c0", pop_log[0], 1'b1);
    chk("a5_pop_count", count_val(SEL_POP, 0, 109, 1'b1), 1);
    chk("a5_tx_c0", tx_log[0], 1'b1);
    fb = {1'b1, 8'hA5, 1'b0};
    mism = 0;
    for (int k = 1; k <= 100; k++) if (tx_log[k] !== fb[(k - 1) / 10]) mism++;
    chk("a5_wave_mism", mism, 0);
    chk("a5_decode", decode(1), 8'hA5);
    chk("a5_done_c100", done_log[100], 1'b1);
    chk("a5_done_count", count_val(SEL_DONE, 0, 109, 1'b1), 1);
    chk("a5_busy_c100", busy_log[100], 1'b1);
    chk("a5_busy_c101", busy_log[101], 1'b0);
    chk("a5_tx_c101", tx_log[101], 1'b1);

    // back-to-back frames
    q = {8'h00, 8'hFF, 8'h3C};
    idle_data = 8'hA5;
    run(320);
    chk("b2b_pop_c0", pop_log[0], 1'b1);
    chk("b2b_pop_c100", pop_log[100], 1'b1);
    chk("b2b_pop_c200", pop_log[200], 1'b1);
    chk("b2b_pop_count", count_val(SEL_POP, 0, 319, 1'b1), 3);
    chk("b2b_no_gap", count_val(SEL_BUSY, 1, 300, 1'b0), 0);
    chk("b2b_stop_c100", tx_log[100], 1'b1);
    chk("b2b_start_c101", tx_log[101], 1'b0);
    chk("b2b_byte0", decode(1), 8'h00);
    chk("b2b_byte1", decode(101), 8'hFF);
    chk("b2b_byte2", decode(201), 8'h3C);
    chk("b2b_done_count", count_val(SEL_DONE, 0, 319, 1'b1), 3);
    chk("b2b_busy_c301", busy_log[301], 1'b0);

    // rdata changes right after the pop
    q = {8'h81};
    idle_data = 8'h5A;
    run(110);
    chk("hold_pop_c0", pop_log[0], 1'b1);
    chk("hold_decode", decode(1), 8'h81);

    // reset in the middle of a frame, then a fresh frame
    q = {8'hC3};
    idle_data = 8'h00;
    rst_at = 45;
    push_at = 50;
    push_val = 8'h5E;
    run(160);
    chk("mrst_tx_c45", tx_log[45], 1'b0);
    chk("mrst_busy_c45", busy_log[45], 1'b1);
    chk("mrst_tx_c46", tx_log[46], 1'b1);
    chk("mrst_busy_c46", busy_log[46], 1'b0);
    chk("mrst_no_done", count_val(SEL_DONE, 0, 149, 1'b1), 0);
    chk("mrst_pop_c50", pop_log[50], 1'b1);
    chk("mrst_pop_count", count_val(SEL_POP, 0, 159, 1'b1), 2);
    chk("mrst_decode", decode(51), 8'h5E);
    chk("mrst_done_c150", done_log[150], 1'b1);

    // FIFO empty on the stop's last clock
    q = {8'h11};
    push_at = 130;
    push_val = 8'h22;
    run(240);
    chk("estop_done_c100", done_log[100], 1'b1);
    chk("estop_no_pop_c100", pop_log[100], 1'b0);
    chk("estop_idle_c101", busy_log[101], 1'b0);
    chk("estop_idle_tx", count_val(SEL_TX, 101, 130, 1'b1), 30);
    chk("estop_pop_c130", pop_log[130], 1'b1);
    chk("estop_start_c131", tx_log[131], 1'b0);
    chk("estop_decode0", decode(1), 8'h11);
    chk("estop_decode1", decode(131), 8'h22);
    chk("estop_done_c230", done_log[230], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
